// File: rtl/vec9_pkg.sv
// Shared definitions for the 9-bit sweep driver.
// Holds the vector width, the last vector value, the match counter width
// and the sweep FSM state type.
package vec9_pkg;

    localparam int VEC_W   = 9;
    localparam int VEC_MAX = (1 << VEC_W) - 1;  // 511: last vector of a sweep
    localparam int CNT_W   = VEC_W + 1;         // holds 0..512 without saturating

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        SAMPLE,
        DONE
    } state_e;

endpackage

// File: rtl/vec9_sweep_driver_if.sv
// Bus between the sweep driver and its controller/detectors.
//   start, abort        : sweep control from the controller
//   outBit1, outBit2    : detector results for the current M
//   M                   : vector driven to both detectors
//   busy, done          : sweep status
//   match_count         : vectors where both detectors reported 1
//   mismatch            : sticky detector-disagreement flag
//   mismatch_vec        : M at the first disagreement
// The sweep driver connects through the slave modport; the controller side
// uses master.
interface vec9_sweep_driver_if #(
    parameter int VEC_W = vec9_pkg::VEC_W
);
    logic             start;
    logic             abort;
    logic             outBit1;
    logic             outBit2;
    logic [VEC_W-1:0] M;
    logic             busy;
    logic             done;
    logic [VEC_W:0]   match_count;
    logic             mismatch;
    logic [VEC_W-1:0] mismatch_vec;

    modport master (
        output start, abort, outBit1, outBit2,
        input  M, busy, done, match_count, mismatch, mismatch_vec
    );

    modport slave (
        input  start, abort, outBit1, outBit2,
        output M, busy, done, match_count, mismatch, mismatch_vec
    );
endinterface

// File: rtl/step_timer.sv
// Loadable down-counter used to hold each sweep vector.
//   clk, rst  : clock, asynchronous active-high reset (value -> 0)
//   load      : load load_val (takes priority over dec)
//   dec       : decrement by one, stopping at zero
//   load_val  : value to load
//   value     : current count
//   zero      : count is zero
module step_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         zero
);
    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (dec && (value_q != '0)) begin
            value_d = value_q - 1'b1;
        end
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign zero  = (value_q == '0);
endmodule

// File: rtl/vec9_sweep_driver.sv
// Sweeps M from 0 to 2**VEC_W-1, holding each vector for STEP_GAP cycles
// (STEP_GAP-1 settle cycles in HOLD, then one SAMPLE cycle), and records
// how the two detectors responded.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of vec9_sweep_driver_if (control in, detector
//              results in, vector and result registers out)
// All outputs come straight from flops.
module vec9_sweep_driver #(
    parameter int STEP_GAP = 10,
    parameter int VEC_W    = vec9_pkg::VEC_W
) (
    input  logic                  clk,
    input  logic                  rst,
    vec9_sweep_driver_if.slave    bus
);
    import vec9_pkg::*;

    localparam logic [7:0]       GAP_M1 = 8'(STEP_GAP - 1);
    localparam logic [VEC_W-1:0] M_LAST = {VEC_W{1'b1}};

    state_e           state_q, state_d;
    logic [VEC_W-1:0] m_q, m_d;
    logic [VEC_W:0]   mc_q, mc_d;
    logic             mm_q, mm_d;
    logic [VEC_W-1:0] mvec_q, mvec_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             tmr_load;
    logic             tmr_dec;
    logic             tmr_zero;
    logic [7:0]       tmr_value;

    step_timer #(.W(8)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (GAP_M1),
        .value    (tmr_value),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        mc_d     = mc_q;
        mm_d     = mm_q;
        mvec_d   = mvec_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;

        // Abort beats everything, including a simultaneous start; the
        // result registers keep whatever they had.
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_d  = HOLD;
                        m_d      = '0;
                        mc_d     = '0;
                        mm_d     = 1'b0;
                        mvec_d   = '0;
                        tmr_load = 1'b1;
                    end
                end
                HOLD: begin
                    // Leave when the count is about to hit zero, so the timer
                    // reads zero during SAMPLE and a vector spans STEP_GAP cycles.
                    tmr_dec = 1'b1;
                    if (tmr_zero || (tmr_value == 8'd1)) begin
                        state_d = SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (bus.outBit1 && bus.outBit2) begin
                        mc_d = mc_q + 1'b1;
                    end
                    if ((bus.outBit1 != bus.outBit2) && !mm_q) begin
                        mm_d   = 1'b1;
                        mvec_d = m_q;
                    end
                    if (m_q == M_LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d  = HOLD;
                        m_d      = m_q + 1'b1;
                        tmr_load = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == HOLD) || (state_d == SAMPLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            mc_q    <= '0;
            mm_q    <= 1'b0;
            mvec_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            mc_q    <= mc_d;
            mm_q    <= mm_d;
            mvec_q  <= mvec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.M            = m_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.match_count  = mc_q;
    assign bus.mismatch     = mm_q;
    assign bus.mismatch_vec = mvec_q;
endmodule

// File: tb/tb_vec9_sweep_driver.sv
// Testbench for vec9_sweep_driver. Detector responses come from per-vector
// tables; a reference model walks the table to predict each sweep's result,
// which is queued at start and compared by a monitor when done rises.
module tb_vec9_sweep_driver;
    import vec9_pkg::*;

    localparam int GAP1 = 10;
    localparam int GAP2 = 2;

    typedef struct {
        int mc;
        bit mm;
        int mv;
    } res_t;

    typedef struct {
        int m;
        int mc;
        bit mm;
        int mv;
        int start_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    bit   det1 [512];
    bit   det2 [512];
    exp_t sb_q [$];
    exp_t mon_e;
    bit   done_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vec9_sweep_driver_if #(.VEC_W(9)) bus1 ();
    vec9_sweep_driver_if #(.VEC_W(9)) bus2 ();

    vec9_sweep_driver #(.STEP_GAP(GAP1), .VEC_W(9)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    vec9_sweep_driver #(.STEP_GAP(GAP2), .VEC_W(9)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // Detector models: table lookup for dut1, all-ones detectors for dut2.
    always_comb begin
        bus1.outBit1 = det1[bus1.M];
        bus1.outBit2 = det2[bus1.M];
        bus2.outBit1 = (bus2.M == 9'h1FF);
        bus2.outBit2 = (bus2.M == 9'h1FF);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Result of sampling vectors 0..n-1 with the current detector tables.
    function automatic res_t model(input int n);
        res_t r;
        r.mc = 0;
        r.mm = 1'b0;
        r.mv = 0;
        for (int i = 0; i < n; i++) begin
            if (det1[i] && det2[i]) r.mc++;
            if ((det1[i] != det2[i]) && !r.mm) begin
                r.mm = 1'b1;
                r.mv = i;
            end
        end
        return r;
    endfunction

    task automatic randomize_tables();
        for (int i = 0; i < 512; i++) begin
            det1[i] = 1'($urandom_range(0, 1));
            det2[i] = det1[i] ^ ($urandom_range(0, 15) == 0);
        end
    endtask

    // Monitor: compare queued expectations whenever dut1 raises done.
    always @(negedge clk) begin
        if (bus1.done && !done_prev) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", sb_q.size(), 1);
            end else begin
                mon_e = sb_q.pop_front();
                check("sweep_m", bus1.M, mon_e.m);
                check("sweep_match_count", bus1.match_count, mon_e.mc);
                check("sweep_mismatch", bus1.mismatch, mon_e.mm);
                check("sweep_mismatch_vec", bus1.mismatch_vec, mon_e.mv);
                check("sweep_cycles", cyc - mon_e.start_cyc, 512 * GAP1);
                check("sweep_busy_low", bus1.busy, 0);
            end
        end
        done_prev = bus1.done;
    end

    task automatic do_start(output int s_cyc);
        @(negedge clk);
        bus1.start = 1'b1;
        @(posedge clk);
        #1;
        s_cyc = cyc;
        bus1.start = 1'b0;
    endtask

    task automatic wait_sb_empty(input int budget);
        int i = 0;
        while ((sb_q.size() != 0) && (i < budget)) begin
            @(posedge clk);
            i++;
        end
        check("sweep_completed", sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic wait_m(input int target);
        int i = 0;
        while ((bus1.M != 9'(target)) && (i < 6000)) begin
            @(posedge clk);
            #1;
            i++;
        end
        check("reach_m", bus1.M, target);
    endtask

    task automatic full_sweep(input bit check_timing);
        exp_t e;
        res_t r;
        int   s;
        r = model(512);
        do_start(s);
        e.m = 511;
        e.mc = r.mc;
        e.mm = r.mm;
        e.mv = r.mv;
        e.start_cyc = s;
        sb_q.push_back(e);
        check("busy_after_start", bus1.busy, 1);
        check("m_after_start", bus1.M, 0);
        check("done_after_start", bus1.done, 0);
        if (check_timing) begin
            for (int k = 1; k <= 3; k++) begin
                repeat (GAP1) @(posedge clk);
                #1;
                check("m_timing", bus1.M, k);
            end
            repeat (57) @(posedge clk);
            @(negedge clk);
            bus1.start = 1'b1;
            @(posedge clk);
            #1;
            bus1.start = 1'b0;
            check("m_start_ignored", bus1.M, (cyc - s) / GAP1);
            check("busy_start_ignored", bus1.busy, 1);
        end
        wait_sb_empty(6000);
    endtask

    initial begin
        res_t r;
        int   s;
        int   i;

        bus1.start = 1'b0;
        bus1.abort = 1'b0;
        bus2.start = 1'b0;
        bus2.abort = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_m", bus1.M, 0);
        check("reset_busy", bus1.busy, 0);
        check("reset_done", bus1.done, 0);
        check("reset_match_count", bus1.match_count, 0);
        check("reset_mismatch", bus1.mismatch, 0);
        check("reset_mismatch_vec", bus1.mismatch_vec, 0);

        // All-ones detectors, with timing and start-while-busy checks.
        for (int k = 0; k < 512; k++) begin
            det1[k] = (k == 511);
            det2[k] = (k == 511);
        end
        full_sweep(1'b1);

        // Detector 2 follows M[0]; restarted directly from DONE.
        check("done_held", bus1.done, 1);
        for (int k = 0; k < 512; k++) det2[k] = ((k % 2) == 1);
        full_sweep(1'b0);

        // Random detector tables.
        randomize_tables();
        full_sweep(1'b0);

        // Abort at M=100, then abort+start together in IDLE, then restart.
        randomize_tables();
        do_start(s);
        wait_m(100);
        @(negedge clk);
        bus1.abort = 1'b1;
        @(posedge clk);
        #1;
        bus1.abort = 1'b0;
        r = model(100);
        check("abort_busy", bus1.busy, 0);
        check("abort_done", bus1.done, 0);
        check("abort_m", bus1.M, 100);
        check("abort_match_count", bus1.match_count, r.mc);
        check("abort_mismatch", bus1.mismatch, r.mm);
        check("abort_mismatch_vec", bus1.mismatch_vec, r.mv);
        @(negedge clk);
        bus1.start = 1'b1;
        bus1.abort = 1'b1;
        @(posedge clk);
        #1;
        bus1.start = 1'b0;
        bus1.abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_start_busy", bus1.busy, 0);
        check("abort_start_m", bus1.M, 100);
        full_sweep(1'b0);

        // Asynchronous reset at M=300, no spurious start, then a clean sweep.
        randomize_tables();
        do_start(s);
        wait_m(300);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_m", bus1.M, 0);
        check("rst_busy", bus1.busy, 0);
        check("rst_done", bus1.done, 0);
        check("rst_match_count", bus1.match_count, 0);
        check("rst_mismatch", bus1.mismatch, 0);
        check("rst_mismatch_vec", bus1.mismatch_vec, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_busy", bus1.busy, 0);
        check("post_rst_m", bus1.M, 0);
        full_sweep(1'b0);

        // STEP_GAP=2 instance: full sweep in 1024 cycles.
        @(negedge clk);
        bus2.start = 1'b1;
        @(posedge clk);
        #1;
        s = cyc;
        bus2.start = 1'b0;
        i = 0;
        while (!bus2.done && (i < 2000)) begin
            @(posedge clk);
            #1;
            i++;
        end
        check("gap2_cycles", cyc - s, 512 * GAP2);
        check("gap2_m", bus2.M, 511);
        check("gap2_match_count", bus2.match_count, 1);
        check("gap2_mismatch", bus2.mismatch, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
